// File: rtl/conv_acc_relu.sv
// Convolution window accumulator with bias, round-half-up rescale, optional ReLU and signed saturation.
// Optional feature macro: CONV_ACC_RELU_EN (clamps negative results to zero before saturation).
module conv_acc_relu #(
   parameter int ACC_W = 40,
   parameter int SHIFT = 8,
   parameter int OUT_W = 16
) (
   input  logic             ap_clk,
   input  logic             ap_rst_n,
   input  logic [31:0]      in_data,
   input  logic             in_last,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      bias,
   output logic [OUT_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             sat_flag
);

   localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
   localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;
   localparam logic [ACC_W-1:0]        RND     = ACC_W'(64'd1 << (SHIFT-1));

   typedef enum logic [0:0] {ST_ACC = 1'b0, ST_OUT = 1'b1} state_t;

   state_t                  state_r;
   state_t                  state_s;
   logic signed [ACC_W-1:0] acc_r;
   logic signed [ACC_W-1:0] base_s;
   logic signed [ACC_W-1:0] sum_s;
   logic signed [ACC_W-1:0] rnd_s;
   logic signed [ACC_W-1:0] res_s;
   logic [OUT_W:0]          sat_s;
   logic                    first_r;
   logic                    in_ready_s;
   logic                    out_valid_s;
   logic                    accept_s;
   logic                    hs_s;
   logic [OUT_W-1:0]        out_data_r;
   logic                    sat_r;

   // Returns {clamped, value}; negatives are zeroed first when ReLU is built in.
   function automatic logic [OUT_W:0] sat_relu(input logic signed [ACC_W-1:0] r);
      logic [OUT_W:0] res;
`ifdef CONV_ACC_RELU_EN
      if (r[ACC_W-1]) begin
         res = {1'b0, {OUT_W{1'b0}}};
      end else if (r > OUT_MAX) begin
         res = {1'b1, OUT_MAX[OUT_W-1:0]};
      end else begin
         res = {1'b0, r[OUT_W-1:0]};
      end
`else
      if (r > OUT_MAX) begin
         res = {1'b1, OUT_MAX[OUT_W-1:0]};
      end else if (r < OUT_MIN) begin
         res = {1'b1, OUT_MIN[OUT_W-1:0]};
      end else begin
         res = {1'b0, r[OUT_W-1:0]};
      end
`endif
      return res;
   endfunction

   assign accept_s  = in_valid && in_ready_s;
   assign hs_s      = out_valid_s && out_ready;
   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_s;
   assign out_data  = out_data_r;
   assign sat_flag  = sat_r;

   // Running sum including the current beat, then rescale and clamp of that sum.
   always_comb begin
      base_s = first_r ? ACC_W'($signed(bias)) : acc_r;
      sum_s  = base_s + ACC_W'($signed(in_data));
      rnd_s  = sum_s + RND;
      res_s  = rnd_s >>> SHIFT;
      sat_s  = sat_relu(res_s);
   end

   // State register and datapath registers.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_r    <= ST_ACC;
         acc_r      <= {ACC_W{1'b0}};
         first_r    <= 1'b1;
         out_data_r <= {OUT_W{1'b0}};
         sat_r      <= 1'b0;
      end else begin
         state_r <= state_s;
         if (accept_s) begin
            acc_r   <= sum_s;
            first_r <= 1'b0;
            if (in_last) begin
               out_data_r <= sat_s[OUT_W-1:0];
               sat_r      <= sat_r | sat_s[OUT_W];
            end else begin
               out_data_r <= out_data_r;
            end
         end else if (hs_s) begin
            first_r <= 1'b1;
         end else begin
            first_r <= first_r;
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_ACC: begin
            if (accept_s && in_last) state_s = ST_OUT;
            else                     state_s = ST_ACC;
         end
         ST_OUT: begin
            if (hs_s) state_s = ST_ACC;
            else      state_s = ST_OUT;
         end
         default: state_s = ST_ACC;
      endcase
   end

   // Handshake outputs decoded from the state register.
   always_comb begin
      in_ready_s  = 1'b0;
      out_valid_s = 1'b0;
      case (state_r)
         ST_ACC:  in_ready_s  = 1'b1;
         ST_OUT:  out_valid_s = 1'b1;
         default: begin
            in_ready_s  = 1'b0;
            out_valid_s = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_conv_acc_relu.sv
// Scoreboard bench for conv_acc_relu: directed windows plus randomized windows against an arithmetic model.
module tb_conv_acc_relu;
   localparam int ACC_W = 40;
   localparam int SHIFT = 8;
   localparam int OUT_W = 16;

   logic             ap_clk = 1'b0;
   logic             ap_rst_n = 1'b0;
   logic [31:0]      in_data = 32'd0;
   logic             in_last = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [31:0]      bias = 32'd0;
   logic [OUT_W-1:0] out_data;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic             sat_flag;

   typedef struct {
      logic [OUT_W-1:0] data;
      logic             sat;
   } exp_t;

   exp_t             sb[$];
   longint           pq[$];
   int               checks = 0;
   int               errors = 0;
   logic             model_sat = 1'b0;
   bit               force_low = 1'b0;
   bit               rand_ready = 1'b0;
   bit               hold_prev = 1'b0;
   logic [OUT_W-1:0] prev_data;

   conv_acc_relu #(.ACC_W(ACC_W), .SHIFT(SHIFT), .OUT_W(OUT_W)) dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_data(in_data), .in_last(in_last),
      .in_valid(in_valid), .in_ready(in_ready), .bias(bias), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .sat_flag(sat_flag)
   );

   always #5 ap_clk = ~ap_clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
      end
   endtask

   // Reference: exact integer sum, floor((sum + half) / 2^SHIFT), optional ReLU, clamp.
   task automatic push_expected(input longint b);
      longint sum;
      longint r;
      longint max_v;
      logic   s;
      exp_t   e;
      sum = b;
      foreach (pq[i]) sum += pq[i];
      r = (sum + (longint'(1) <<< (SHIFT-1))) >>> SHIFT;
`ifdef CONV_ACC_RELU_EN
      if (r < 0) r = 0;
`endif
      max_v = (longint'(1) <<< (OUT_W-1)) - 1;
      s = 1'b0;
      if (r > max_v) begin r = max_v; s = 1'b1; end
      if (r < -max_v - 1) begin r = -max_v - 1; s = 1'b1; end
      model_sat = model_sat | s;
      e.data = r[OUT_W-1:0];
      e.sat  = model_sat;
      sb.push_back(e);
   endtask

   task automatic send_beat(input logic [31:0] d, input logic l, input logic [31:0] b);
      int guard;
      @(negedge ap_clk);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      bias     = b;
      guard    = 0;
      while (!in_ready && guard < 200) begin
         @(negedge ap_clk);
         guard++;
      end
      if (guard >= 200) begin
         checks++;
         errors++;
         $display("FAIL beat_timeout: in_ready stayed %0d, required 1", in_ready);
      end
      @(posedge ap_clk);
      if (l) begin
         @(negedge ap_clk);
         in_valid = 1'b0;
         check("latency_out_valid", 64'(out_valid), 64'd1);
      end
   endtask

   task automatic idle();
      @(negedge ap_clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Later beats carry random bias, which the design must ignore.
   task automatic send_window(input longint b);
      longint p;
      push_expected(b);
      foreach (pq[i]) begin
         p = pq[i];
         send_beat(p[31:0], (i == pq.size() - 1), (i == 0) ? b[31:0] : $urandom);
      end
   endtask

   task automatic wait_drain();
      int guard;
      guard = 0;
      while (sb.size() != 0 && guard < 500) begin
         @(negedge ap_clk);
         guard++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      end
   endtask

   // Consumer: updates out_ready just after each rising edge.
   initial begin
      forever begin
         @(posedge ap_clk);
         #1;
         if (force_low)       out_ready = 1'b0;
         else if (rand_ready) out_ready = 1'($urandom_range(0, 1));
         else                 out_ready = 1'b1;
      end
   end

   // Monitor: hold stability under backpressure and scoreboard comparison on handshake.
   initial begin
      exp_t e;
      forever begin
         @(negedge ap_clk);
         if (ap_rst_n) begin
            if (hold_prev) begin
               check("hold_out_valid", 64'(out_valid), 64'd1);
               check("hold_out_data", 64'($signed(out_data)), 64'($signed(prev_data)));
               check("hold_in_ready", 64'(in_ready), 64'd0);
            end
            hold_prev = out_valid && !out_ready;
            prev_data = out_data;
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_output: got %0d with no result outstanding", $signed(out_data));
               end else begin
                  e = sb.pop_front();
                  check("out_data", 64'($signed(out_data)), 64'($signed(e.data)));
                  check("sat_flag", 64'(sat_flag), 64'(e.sat));
               end
            end
         end else begin
            hold_prev = 1'b0;
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (2) @(negedge ap_clk);
      check("rst_out_data", 64'($signed(out_data)), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_sat_flag", 64'(sat_flag), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      ap_rst_n = 1'b1;

      pq.delete(); pq.push_back(256); pq.push_back(512); pq.push_back(768);
      send_window(0);
      pq.delete(); pq.push_back(256);
      send_window(128);
      pq.delete(); pq.push_back(-512); pq.push_back(-512);
      send_window(0);
      wait_drain();

      send_beat(32'd100, 1'b0, 32'd7);
      send_beat(32'd200, 1'b0, 32'd7);
      idle();
      ap_rst_n = 1'b0;
      #2;
      check("midrst_out_data", 64'($signed(out_data)), 64'd0);
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_sat_flag", 64'(sat_flag), 64'd0);
      sb.delete();
      model_sat = 1'b0;
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      pq.delete(); pq.push_back(256);
      send_window(0);

      pq.delete(); repeat (4) pq.push_back(64'h40000000);
      send_window(0);
      pq.delete(); pq.push_back(1000);
      send_window(5);
      wait_drain();

      force_low = 1'b1;
      fork
         begin
            pq.delete(); repeat (3) pq.push_back(256);
            send_window(0);
            pq.delete(); pq.push_back(512); pq.push_back(512);
            send_window(0);
         end
         begin
            int guard;
            guard = 0;
            while (!out_valid && guard < 100) begin
               @(negedge ap_clk);
               guard++;
            end
            repeat (3) @(negedge ap_clk);
            force_low = 1'b0;
         end
      join
      wait_drain();

      rand_ready = 1'b1;
      repeat (40) begin
         n = $urandom_range(1, 6);
         pq.delete();
         repeat (n) begin
            if ($urandom_range(0, 3) == 0) pq.push_back(longint'(int'($urandom)));
            else                           pq.push_back(longint'(int'($urandom_range(0, 8191))) - 4096);
         end
         send_window(longint'(int'($urandom_range(0, 4095))) - 2048);
      end
      wait_drain();
      idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
